// File: rtl/vsdserializer_v1_pkg.sv
// rtl/vsdserializer_v1_pkg.sv - shared constants for the raw-bit parallel-to-serial shifter
package vsdserializer_v1_pkg;

    localparam int DEFAULT_WIDTH = 10;

    // Number of non-load edges after which a loaded word has fully drained.
    function automatic int drain_edges(input int width);
        return width;
    endfunction

endpackage

// File: rtl/vsdserializer_v1_if.sv
// rtl/vsdserializer_v1_if.sv - bundle of the load/word/serial-bit signals around the serializer
interface vsdserializer_v1_if
    import vsdserializer_v1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic             dout;

    modport master (output load, output data, input dout);
    modport slave  (input load, input data, output dout);
endinterface

// File: rtl/vsdserializer_v1.sv
// rtl/vsdserializer_v1.sv - MSB-first parallel-to-serial shift register with load priority
// Plain ports in fixed order so legacy 4-port positional instantiations keep binding.
module vsdserializer_v1
    import vsdserializer_v1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] INPUT,
    output logic             OUTPUT,
    input  logic             reset
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    // Load wins every edge; otherwise shift toward the MSB, zero-filling behind.
    assign sreg_d = load ? INPUT : {sreg_q[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign OUTPUT = sreg_q[WIDTH-1];

endmodule

// File: tb/tb_vsdserializer_v1.sv
// tb/tb_vsdserializer_v1.sv - randomized and directed checks of the serializer against a word/bit-index model
module tb_vsdserializer_v1;

    localparam int W = 10;

    logic clk = 1'b0;
    logic reset;

    vsdserializer_v1_if #(.WIDTH(W)) bus ();

    vsdserializer_v1 #(.WIDTH(W)) dut (
        .clk    (clk),
        .load   (bus.load),
        .INPUT  (bus.data),
        .OUTPUT (bus.dout),
        .reset  (reset)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: the last loaded word and how many non-load edges have passed since.
    logic [W-1:0] m_word;
    int           m_k;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_out();
        if (m_k < W) return m_word[W-1-m_k];
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_word = '0;
        m_k    = W;
    endtask

    task automatic step(input string tag, input logic l, input logic [W-1:0] d);
        @(negedge clk);
        bus.load = l;
        bus.data = d;
        @(posedge clk);
        if (l) begin
            m_word = d;
            m_k    = 0;
        end else if (m_k < W) begin
            m_k++;
        end
        #1;
        check_bit(tag, bus.dout, model_out());
    endtask

    // Called right after a step (posedge+1); the pulse ends before the next negedge.
    task automatic reset_pulse(input string tag);
        #1 reset = 1'b1;
        #1 check_bit(tag, bus.dout, 1'b0);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset    = 1'b1;
        bus.load = 1'b1;
        bus.data = 10'h3FF;
        model_reset();
        #1 check_bit("reset_immediate", bus.dout, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1 check_bit("reset_over_load", bus.dout, 1'b0);
        end
        reset = 1'b0;
        repeat (3) step("post_reset_idle", 1'b0, 10'h3FF);

        step("basic_load", 1'b1, 10'b1011001110);
        repeat (W + 3) step("basic_shift", 1'b0, $urandom);

        step("reload_a", 1'b1, 10'h3FF);
        repeat (3) step("reload_shift", 1'b0, 10'h155);
        step("reload_b", 1'b1, 10'h000);
        repeat (W) step("reload_after", 1'b0, 10'h3FF);

        step("midreset_load", 1'b1, 10'h2AA);
        repeat (4) step("midreset_shift", 1'b0, 10'h000);
        reset_pulse("midreset_async");
        repeat (W) step("midreset_after", 1'b0, 10'h3FF);

        for (int i = 0; i < 5; i++)
            step("held_load", 1'b1, (i % 2 == 0) ? 10'h200 : 10'h1FF);
        repeat (W + 1) step("held_drain", 1'b0, 10'h000);

        for (int i = 0; i < 1000; i++) begin
            step("random", ($urandom_range(0, 5) == 0), W'($urandom));
            if ($urandom_range(0, 63) == 0) reset_pulse("random_reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
